// File: rtl/urv_timer_bank.sv
// Memory-mapped bank of countdown timers for the uRV data bus.
// Each channel holds a count and a reload value and can run one-shot or
// periodic, ticking once every g_prescale clock cycles. Expiries latch
// bits in a write-1-to-clear pending register that drives a level interrupt.
module urv_timer_bank #(
    parameter int unsigned g_num_channels  = 4,
    parameter int unsigned g_counter_width = 16,
    parameter int unsigned g_prescale      = 1,
    parameter logic [31:0] g_base_addr     = 32'h00100004
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_store_done_o,
    output logic        dm_load_done_o,
    output logic        irq_o
);

    localparam int N = int'(g_num_channels);
    localparam int W = int'(g_counter_width);
    localparam logic [15:0]  PRESC_MAX = 16'(g_prescale - 1);
    localparam logic [W-1:0] COUNT_ONE = W'(1);
    localparam logic [29:0]  PEND_WORD = 30'd16;

    logic [W-1:0] count      [N];
    logic [W-1:0] reload     [N];
    logic [W-1:0] count_nxt  [N];
    logic [W-1:0] reload_nxt [N];
    logic [N-1:0] enable, periodic, irq_en, pending;
    logic [N-1:0] enable_nxt, periodic_nxt, irq_en_nxt, pending_nxt;
    logic [N-1:0] pending_set, pending_clr;
    logic [15:0]  presc;
    logic         tick;
    logic         wr_en;
    logic [29:0]  word_off;
    logic [31:0]  rd_data;
    logic         unused;

    // Word offset from the bank base; byte-lane bits of the address are ignored.
    assign word_off = dm_addr_i[31:2] - g_base_addr[31:2];
    assign wr_en    = dm_store_i && (dm_data_select_i == 4'b1111);
    assign tick     = (presc == PRESC_MAX);

    // Stores are acknowledged immediately whatever the address.
    assign dm_store_done_o = dm_store_i;

    assign unused = &{1'b0, dm_addr_i[1:0], dm_data_s_i};

    // Free-running prescaler; the tick is the cycle in which it wraps.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 16'd1;
        end
    end

    // Next state of every channel: a LOAD write overrides any tick activity,
    // a CTRL write overrides the enable clear of a one-shot expiry.
    always_comb begin
        enable_nxt   = enable;
        periodic_nxt = periodic;
        irq_en_nxt   = irq_en;
        pending_set  = '0;
        pending_clr  = '0;
        for (int ch = 0; ch < N; ch++) begin
            count_nxt[ch]  = count[ch];
            reload_nxt[ch] = reload[ch];
            if (wr_en && (word_off == 30'(2 * ch))) begin
                count_nxt[ch]  = dm_data_s_i[W-1:0];
                reload_nxt[ch] = dm_data_s_i[W-1:0];
            end else if (tick && enable[ch]) begin
                if (count[ch] == COUNT_ONE) begin
                    pending_set[ch] = 1'b1;
                    if (periodic[ch]) begin
                        count_nxt[ch] = reload[ch];
                    end else begin
                        count_nxt[ch]  = '0;
                        enable_nxt[ch] = 1'b0;
                    end
                end else if (count[ch] != '0) begin
                    count_nxt[ch] = count[ch] - COUNT_ONE;
                end
            end
            if (wr_en && (word_off == 30'(2 * ch + 1))) begin
                enable_nxt[ch]   = dm_data_s_i[0];
                periodic_nxt[ch] = dm_data_s_i[1];
                irq_en_nxt[ch]   = dm_data_s_i[2];
            end
        end
        if (wr_en && (word_off == PEND_WORD)) begin
            pending_clr = dm_data_s_i[N-1:0];
        end
        pending_nxt = (pending & ~pending_clr) | pending_set;
    end

    // Register file state, including the interrupt computed from next-state values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int ch = 0; ch < N; ch++) begin
                count[ch]  <= '0;
                reload[ch] <= '0;
            end
            enable   <= '0;
            periodic <= '0;
            irq_en   <= '0;
            pending  <= '0;
            irq_o    <= 1'b0;
        end else begin
            for (int ch = 0; ch < N; ch++) begin
                count[ch]  <= count_nxt[ch];
                reload[ch] <= reload_nxt[ch];
            end
            enable   <= enable_nxt;
            periodic <= periodic_nxt;
            irq_en   <= irq_en_nxt;
            pending  <= pending_nxt;
            irq_o    <= |(pending_nxt & irq_en_nxt);
        end
    end

    // Read multiplexer over the current register contents.
    always_comb begin
        rd_data = '0;
        for (int ch = 0; ch < N; ch++) begin
            if (word_off == 30'(2 * ch)) begin
                rd_data[W-1:0] = count[ch];
            end else if (word_off == 30'(2 * ch + 1)) begin
                rd_data[2:0] = {irq_en[ch], periodic[ch], enable[ch]};
            end
        end
        if (word_off == PEND_WORD) begin
            rd_data[N-1:0] = pending;
        end
    end

    // Loads complete one cycle after the strobe.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            dm_load_done_o <= 1'b0;
            dm_data_l_o    <= '0;
        end else begin
            dm_load_done_o <= dm_load_i;
            dm_data_l_o    <= dm_load_i ? rd_data : 32'h0;
        end
    end

endmodule

// File: tb/tb_urv_timer_bank.sv
// Self-checking bench for urv_timer_bank: a behavioural model of the
// register bank predicts load data and the interrupt level, loads are
// queued on a scoreboard and a separate monitor compares DUT responses.
module tb_urv_timer_bank;

    localparam int N = 4;
    localparam int W = 16;
    localparam int P = 3;
    localparam logic [31:0] BASE = 32'h00100004;
    localparam logic [31:0] MASK = (W >= 32) ? 32'hFFFF_FFFF : 32'((64'd1 << W) - 64'd1);

    logic        clk;
    logic        rst_n;
    logic [31:0] dm_addr;
    logic [31:0] dm_data_s;
    logic [3:0]  dm_data_select;
    logic        dm_store;
    logic        dm_load;
    logic [31:0] dm_data_l;
    logic        dm_store_done;
    logic        dm_load_done;
    logic        irq;

    typedef struct {
        int unsigned tag;
        logic [31:0] data;
    } rd_item_t;

    logic [31:0] m_cnt [N];
    logic [31:0] m_rel [N];
    logic [2:0]  m_ctl [N];
    logic [N-1:0] m_pend;
    logic        m_irq;
    int unsigned since_rst;
    int unsigned cyc_no;
    rd_item_t    rd_q[$];

    int n_cmp;
    int n_err;

    urv_timer_bank #(
        .g_num_channels (N),
        .g_counter_width(W),
        .g_prescale     (P),
        .g_base_addr    (BASE)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .dm_addr_i       (dm_addr),
        .dm_data_s_i     (dm_data_s),
        .dm_data_select_i(dm_data_select),
        .dm_store_i      (dm_store),
        .dm_load_i       (dm_load),
        .dm_data_l_o     (dm_data_l),
        .dm_store_done_o (dm_store_done),
        .dm_load_done_o  (dm_load_done),
        .irq_o           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference view of a register read, from the map rules.
    function automatic logic [31:0] modelRead(input logic [31:0] addr);
        logic [31:0] off;
        int ch;
        off = {addr[31:2], 2'b00} - BASE;
        if (off < 32'(8 * N)) begin
            ch = int'(off / 8);
            if (off % 8 == 0) return m_cnt[ch];
            return {29'd0, m_ctl[ch]};
        end
        if (off == 32'h40) return 32'(m_pend);
        return 32'h0;
    endfunction

    task automatic modelReset();
        for (int ch = 0; ch < N; ch++) begin
            m_cnt[ch] = 0;
            m_rel[ch] = 0;
            m_ctl[ch] = 0;
        end
        m_pend    = '0;
        m_irq     = 1'b0;
        since_rst = 0;
        rd_q.delete();
    endtask

    // One clock of the behavioural model, using the inputs held across the edge.
    task automatic modelStep();
        logic [31:0] off;
        logic [N-1:0] set_v;
        logic [N-1:0] clr_v;
        logic [N-1:0] ien;
        bit tick;
        bit wr;
        cyc_no++;
        if (dm_load) rd_q.push_back('{cyc_no, modelRead(dm_addr)});
        tick = (since_rst % P) == P - 1;
        since_rst++;
        wr = dm_store && (dm_data_select == 4'hF);
        off = {dm_addr[31:2], 2'b00} - BASE;
        set_v = '0;
        clr_v = '0;
        for (int ch = 0; ch < N; ch++) begin
            if (wr && off == 32'(8 * ch)) begin
                m_cnt[ch] = dm_data_s & MASK;
                m_rel[ch] = dm_data_s & MASK;
            end else if (tick && m_ctl[ch][0]) begin
                if (m_cnt[ch] > 1) begin
                    m_cnt[ch] = m_cnt[ch] - 1;
                end else if (m_cnt[ch] == 1) begin
                    set_v[ch] = 1'b1;
                    if (m_ctl[ch][1]) begin
                        m_cnt[ch] = m_rel[ch];
                    end else begin
                        m_cnt[ch] = 0;
                        m_ctl[ch][0] = 1'b0;
                    end
                end
            end
            if (wr && off == 32'(8 * ch + 4)) m_ctl[ch] = dm_data_s[2:0];
        end
        if (wr && off == 32'h40) clr_v = dm_data_s[N-1:0];
        m_pend = (m_pend & ~clr_v) | set_v;
        for (int ch = 0; ch < N; ch++) ien[ch] = m_ctl[ch][2];
        m_irq = |(m_pend & ien);
    endtask

    function automatic bit expiryNext(input int ch);
        return (m_cnt[ch] == 1) && m_ctl[ch][0] && ((since_rst % P) == P - 1);
    endfunction

    // Model process: follows the DUT clock and asynchronous reset.
    initial begin
        cyc_no = 0;
        modelReset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) modelReset();
            else modelStep();
        end
    end

    // Monitor: pops expected load responses and checks the interrupt level.
    initial begin
        rd_item_t item;
        bit exp_done;
        forever begin
            @(negedge clk);
            exp_done = (rd_q.size() > 0) && (rd_q[0].tag == cyc_no);
            checkOutput("load_done", {31'd0, dm_load_done}, {31'd0, exp_done});
            if (exp_done) begin
                item = rd_q.pop_front();
                checkOutput("load_data", dm_data_l, item.data);
            end
            checkOutput("irq", {31'd0, irq}, {31'd0, m_irq});
        end
    end

    // Drives one bus cycle starting at a falling edge and returns at the next one.
    task automatic applyStimulus(input logic st, input logic ld, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [3:0] sel);
        dm_store       = st;
        dm_load        = ld;
        dm_addr        = addr;
        dm_data_s      = data;
        dm_data_select = sel;
        #1;
        checkOutput("store_done", {31'd0, dm_store_done}, {31'd0, st});
        @(negedge clk);
    endtask

    task automatic writeReg(input logic [31:0] off, input logic [31:0] data);
        applyStimulus(1'b1, 1'b0, BASE + off, data, 4'hF);
    endtask

    task automatic readReg(input logic [31:0] off);
        applyStimulus(1'b0, 1'b1, BASE + off, 32'h0, 4'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic waitExpiry(input int ch, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (expiryNext(ch)) begin
                ok = 1'b1;
                return;
            end
            idle(1);
        end
        n_cmp++;
        n_err++;
        $display("[TB] FAIL expiry_wait ch%0d: got no expiry, expected one within 80 cycles", ch);
    endtask

    // Global time limit so the run always terminates.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios followed by randomized traffic.
    initial begin
        bit ok;
        int r;
        int ch;
        logic [31:0] off;
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        dm_store = 1'b0;
        dm_load = 1'b0;
        dm_addr = '0;
        dm_data_s = '0;
        dm_data_select = '0;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_irq", {31'd0, irq}, 32'h0);
        checkOutput("reset_done", {31'd0, dm_load_done}, 32'h0);
        checkOutput("reset_data", dm_data_l, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // One-shot channel 0 with interrupt.
        writeReg(32'h0, 32'd5);
        writeReg(32'h4, 32'd5);
        for (int i = 0; i < 20; i++) readReg(32'h0);
        readReg(32'h4);
        readReg(32'h40);

        // Periodic channel 1, then clear its pending bit.
        writeReg(32'hC, 32'd7);
        writeReg(32'h8, 32'd3);
        for (int i = 0; i < 24; i++) readReg(32'h8);
        writeReg(32'h40, 32'h2);
        readReg(32'h40);
        writeReg(32'hC, 32'd0);
        writeReg(32'h40, 32'hF);

        // Partial-lane store, unmapped read, low address bits ignored.
        applyStimulus(1'b1, 1'b0, BASE, 32'h1234, 4'b0011);
        readReg(32'h0);
        readReg(32'h3C);
        applyStimulus(1'b0, 1'b1, BASE + 32'h43, 32'h0, 4'h0);
        applyStimulus(1'b1, 1'b0, BASE + 32'h24, 32'hFFFF_FFFF, 4'hF);

        // LOAD write on the expiry edge beats the expiry.
        writeReg(32'h10, 32'd2);
        writeReg(32'h14, 32'd5);
        waitExpiry(2, ok);
        if (ok) writeReg(32'h10, 32'd9);
        readReg(32'h40);
        readReg(32'h10);
        readReg(32'h14);

        // PENDING clear on the expiry edge loses to the set.
        waitExpiry(2, ok);
        if (ok) writeReg(32'h40, 32'h4);
        readReg(32'h40);
        idle(2);

        // Dropping irq_en lowers the interrupt without touching pending.
        writeReg(32'h14, 32'd0);
        readReg(32'h40);

        // Upper store bits are dropped.
        writeReg(32'h18, 32'h0001_FFFF);
        readReg(32'h18);

        // Reset in the middle of a count while outputs are active.
        writeReg(32'h14, 32'd4);
        writeReg(32'h0, 32'd20);
        writeReg(32'h4, 32'd7);
        idle(4);
        readReg(32'h0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_irq", {31'd0, irq}, 32'h0);
        checkOutput("midreset_done", {31'd0, dm_load_done}, 32'h0);
        checkOutput("midreset_data", dm_data_l, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        readReg(32'h0);
        readReg(32'h40);
        idle(20);

        // Randomized traffic.
        for (int i = 0; i < 700; i++) begin
            r = $urandom_range(0, 99);
            ch = $urandom_range(0, N - 1);
            if (r < 15) begin
                writeReg(32'(8 * ch), (r < 2) ? $urandom : 32'($urandom_range(0, 8)));
            end else if (r < 27) begin
                writeReg(32'(8 * ch + 4), 32'($urandom_range(0, 7)));
            end else if (r < 31) begin
                writeReg(32'h40, $urandom);
            end else if (r < 35) begin
                applyStimulus(1'b1, 1'b0, BASE + 32'(8 * ch), $urandom, 4'($urandom_range(0, 14)));
            end else if (r < 38) begin
                applyStimulus(1'b1, 1'b0, BASE + 32'h20 + 32'(4 * $urandom_range(0, 7)), $urandom, 4'hF);
            end else if (r < 72) begin
                case ($urandom_range(0, 4))
                    0: off = 32'(8 * ch);
                    1: off = 32'(8 * ch + 4);
                    2: off = 32'h40;
                    3: off = 32'h3C;
                    default: off = 32'($urandom_range(0, 80));
                endcase
                readReg(off);
            end else begin
                idle(1);
            end
        end
        idle(4);
        checkOutput("queue_drain", 32'(rd_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
